// File: rtl/switch_press_decoder.sv
// -----------------------------------------------------------------------------
// switch_press_decoder
//
// Classifies presses of a debounced switch level into SHORT, LONG, DOUBLE and
// LONG_RELEASE events and measures their duration in timing ticks. Events are
// presented one at a time through a valid/ack holding register.
//
// Ports:
//   clk                 clock
//   clk__enable         global clock enable; when 0 nothing changes state
//   reset_n             asynchronous active-low reset
//   switch_value        filtered switch level (1 = pressed)
//   clk_enable          timing tick; the duration counter advances on it
//   long_press_ticks    ticks held before LONG is emitted (0 = disabled)
//   double_click_ticks  ticks to wait for a second press (0 = disabled)
//   event_ack           consumer accepts the held event
//   event_valid         an event is held in the output register
//   event_type          0=SHORT 1=LONG 2=DOUBLE 3=LONG_RELEASE
//   event_duration      duration in ticks attached to the event
//   event_overrun       sticky flag: an event was dropped while one was held
//   pressed             registered copy of switch_value
// -----------------------------------------------------------------------------
module switch_press_decoder (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        switch_value,
  input  logic        clk_enable,
  input  logic [15:0] long_press_ticks,
  input  logic [15:0] double_click_ticks,
  input  logic        event_ack,
  output logic        event_valid,
  output logic [1:0]  event_type,
  output logic [15:0] event_duration,
  output logic        event_overrun,
  output logic        pressed
);

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_WAIT_SECOND    = 3'd2,
    ST_SECOND_PRESSED = 3'd3,
    ST_LONG_HELD      = 3'd4
  } state_t;

  localparam logic [1:0] EV_SHORT        = 2'd0;
  localparam logic [1:0] EV_LONG         = 2'd1;
  localparam logic [1:0] EV_DOUBLE       = 2'd2;
  localparam logic [1:0] EV_LONG_RELEASE = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] saved_q, saved_d;
  logic        prev_q;
  logic        valid_q, valid_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] dur_q, dur_d;
  logic        overrun_q, overrun_d;

  logic        rise_s;
  logic        fall_s;
  logic [15:0] tick_inc_s;
  logic [16:0] tick_plus1_s;
  logic        reach_long_s;
  logic        reach_double_s;
  logic        emit_s;
  logic [1:0]  emit_type_s;
  logic [15:0] emit_dur_s;

  // Edge detection, saturating increment and threshold comparisons.
  always_comb begin
    rise_s       = switch_value & ~prev_q;
    fall_s       = ~switch_value & prev_q;
    tick_inc_s   = (tick_q == 16'hFFFF) ? 16'hFFFF : (tick_q + 16'd1);
    // 17-bit compare so a saturated counter can never alias to a threshold.
    tick_plus1_s = {1'b0, tick_q} + 17'd1;
    reach_long_s = clk_enable && (long_press_ticks != 16'd0) &&
                   (tick_plus1_s == {1'b0, long_press_ticks});
    reach_double_s = clk_enable && (double_click_ticks != 16'd0) &&
                     (tick_plus1_s == {1'b0, double_click_ticks});
  end

  // Press classification FSM next-state and event request.
  always_comb begin
    state_d     = state_q;
    tick_d      = clk_enable ? tick_inc_s : tick_q;
    saved_d     = saved_q;
    emit_s      = 1'b0;
    emit_type_s = EV_SHORT;
    emit_dur_s  = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_PRESSED;
          tick_d  = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        // A release in the same cycle as the long threshold takes priority.
        if (fall_s) begin
          saved_d = tick_q;
          if (double_click_ticks == 16'd0) begin
            emit_s      = 1'b1;
            emit_type_s = EV_SHORT;
            emit_dur_s  = tick_q;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT_SECOND;
            tick_d  = 16'd0;
          end
        end else if (reach_long_s) begin
          emit_s      = 1'b1;
          emit_type_s = EV_LONG;
          emit_dur_s  = long_press_ticks;
          state_d     = ST_LONG_HELD;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_WAIT_SECOND: begin
        // A second press beats the timeout in the same cycle.
        if (rise_s) begin
          state_d = ST_SECOND_PRESSED;
          tick_d  = 16'd0;
        end else if (reach_double_s) begin
          emit_s      = 1'b1;
          emit_type_s = EV_SHORT;
          emit_dur_s  = saved_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SECOND;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall_s) begin
          emit_s      = 1'b1;
          emit_type_s = EV_DOUBLE;
          emit_dur_s  = saved_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SECOND_PRESSED;
        end
      end
      ST_LONG_HELD: begin
        if (fall_s) begin
          emit_s      = 1'b1;
          emit_type_s = EV_LONG_RELEASE;
          emit_dur_s  = tick_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_LONG_HELD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = 16'd0;
      end
    endcase
  end

  // Output holding register with valid/ack handshake and sticky overrun.
  always_comb begin
    valid_d   = valid_q;
    type_d    = type_q;
    dur_d     = dur_q;
    overrun_d = overrun_q;
    if (emit_s) begin
      // An ack in the emit cycle frees the slot for a back-to-back load.
      if (!valid_q || event_ack) begin
        valid_d = 1'b1;
        type_d  = emit_type_s;
        dur_d   = emit_dur_s;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && event_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= 16'd0;
      saved_q   <= 16'd0;
      prev_q    <= 1'b0;
      valid_q   <= 1'b0;
      type_q    <= 2'd0;
      dur_q     <= 16'd0;
      overrun_q <= 1'b0;
    end else if (clk__enable) begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      saved_q   <= saved_d;
      prev_q    <= switch_value;
      valid_q   <= valid_d;
      type_q    <= type_d;
      dur_q     <= dur_d;
      overrun_q <= overrun_d;
    end
  end

  assign event_valid    = valid_q;
  assign event_type     = type_q;
  assign event_duration = dur_q;
  assign event_overrun  = overrun_q;
  assign pressed        = prev_q;

endmodule

// File: tb/tb_switch_press_decoder.sv
// -----------------------------------------------------------------------------
// tb_switch_press_decoder
//
// Directed, table-driven bench for switch_press_decoder. Each table row is one
// clock cycle of inputs plus the hand-computed outputs after that edge.
// Multi-cycle corner cases (long press, reset, saturation) are hand sequences.
// -----------------------------------------------------------------------------
module tb_switch_press_decoder;

  logic        clk;
  logic        clk__enable;
  logic        reset_n;
  logic        switch_value;
  logic        clk_enable;
  logic [15:0] long_press_ticks;
  logic [15:0] double_click_ticks;
  logic        event_ack;
  logic        event_valid;
  logic [1:0]  event_type;
  logic [15:0] event_duration;
  logic        event_overrun;
  logic        pressed;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        sw;
    logic        tk;
    logic        ack;
    logic        ev;
    logic [1:0]  et;
    logic [15:0] ed;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  switch_press_decoder dut (
    .clk                (clk),
    .clk__enable        (clk__enable),
    .reset_n            (reset_n),
    .switch_value       (switch_value),
    .clk_enable         (clk_enable),
    .long_press_ticks   (long_press_ticks),
    .double_click_ticks (double_click_ticks),
    .event_ack          (event_ack),
    .event_valid        (event_valid),
    .event_type         (event_type),
    .event_duration     (event_duration),
    .event_overrun      (event_overrun),
    .pressed            (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic sw, input logic tk, input logic ack,
                     input logic ev, input logic [1:0] et, input logic [15:0] ed,
                     input logic eo);
    for (int k = 0; k < n; k++) vecs.push_back('{sw, tk, ack, ev, et, ed, eo});
  endtask

  // Drive one cycle of inputs at the falling edge, return 1 time unit after
  // the following rising edge so outputs can be sampled.
  task automatic step(input logic sw, input logic tk, input logic ack);
    @(negedge clk);
    switch_value = sw;
    clk_enable   = tk;
    event_ack    = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    switch_value = 1'b0;
    clk_enable   = 1'b0;
    event_ack    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"},   32'(event_valid),    32'd0);
    chk({name, "_type"},    32'(event_type),     32'd0);
    chk({name, "_dur"},     32'(event_duration), 32'd0);
    chk({name, "_overrun"}, 32'(event_overrun),  32'd0);
    chk({name, "_pressed"}, 32'(pressed),        32'd0);
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    reset_n            = 1'b0;
    clk__enable        = 1'b1;
    switch_value       = 1'b0;
    clk_enable         = 1'b0;
    event_ack          = 1'b0;
    long_press_ticks   = 16'd10;
    double_click_ticks = 16'd5;

    // args: n, sw, tk, ack, exp valid, exp type, exp duration, exp overrun
    // Short press: 3 ticks held, SHORT after 5 idle ticks.
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    add(4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
    add(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd3, 1'b0);
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd3, 1'b0);
    // Double click: 2 ticks, 3 ticks gap, second press; no SHORT afterwards.
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd2, 1'b0);
    add(6, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 16'd2, 1'b0);
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'd2, 1'b0);
    // Two SHORTs without ack: first kept, second dropped with overrun.
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'd2, 1'b0);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'd2, 1'b0);
    add(4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2, 1'b0);
    add(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1, 1'b0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1, 1'b0);
    add(4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b0);
    add(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b1);
    // Ack in the emit cycle: back-to-back load, valid stays high.
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1, 1'b1);
    add(3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b1);
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1, 1'b1);
    add(4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd1, 1'b1);
    add(1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd3, 1'b1);
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd3, 1'b1);
    // Release coinciding with long threshold: release wins, SHORT(9) later.
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b1);
    add(9, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b1);
    add(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b1);
    add(4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3, 1'b1);
    add(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'd9, 1'b1);
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd9, 1'b1);
    // Second press coinciding with double-click timeout: press wins.
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd9, 1'b1);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd9, 1'b1);
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd9, 1'b1);
    add(4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd9, 1'b1);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd9, 1'b1);
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1, 1'b1);
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'd1, 1'b1);

    // Reset values while reset is held.
    #22;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sw, vecs[i].tk, vecs[i].ack);
      chk($sformatf("vec%0d", i),
          {11'd0, event_valid, event_type, event_duration, event_overrun, pressed},
          {11'd0, vecs[i].ev, vecs[i].et, vecs[i].ed, vecs[i].eo, vecs[i].sw});
    end

    // Long press: LONG at the 10th tick while held, LONG_RELEASE(25) on release.
    do_reset();
    chk("post_reset_overrun", 32'(event_overrun), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b1, 1'b1, 1'b0);
    chk("long_before_valid", 32'(event_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("long_valid",   32'(event_valid),    32'd1);
    chk("long_type",    32'(event_type),     32'd1);
    chk("long_dur",     32'(event_duration), 32'd10);
    chk("long_pressed", 32'(pressed),        32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("long_ack_valid", 32'(event_valid), 32'd0);
    repeat (15) step(1'b1, 1'b1, 1'b0);
    chk("long_held_valid", 32'(event_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("lrel_valid", 32'(event_valid),    32'd1);
    chk("lrel_type",  32'(event_type),     32'd3);
    chk("lrel_dur",   32'(event_duration), 32'd25);

    // LONG while LONG_RELEASE is still unacked: dropped, overrun set.
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    chk("drop_overrun", 32'(event_overrun),  32'd1);
    chk("drop_type",    32'(event_type),     32'd3);
    chk("drop_dur",     32'(event_duration), 32'd25);

    // Asynchronous reset in LONG_HELD with event_valid=1.
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step(1'b1, 1'b1, 1'b0);
    chk("after_reset_valid",   32'(event_valid), 32'd0);
    chk("after_reset_pressed", 32'(pressed),     32'd1);

    // Both features disabled: saturating duration, immediate SHORT.
    do_reset();
    long_press_ticks   = 16'd0;
    double_click_ticks = 16'd0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 32'h1_0005; k++) step(1'b1, 1'b1, 1'b0);
    chk("sat_held_valid", 32'(event_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("sat_valid", 32'(event_valid),    32'd1);
    chk("sat_type",  32'(event_type),     32'd0);
    chk("sat_dur",   32'(event_duration), 32'hFFFF);

    // Global enable low: inputs are ignored, nothing changes.
    @(negedge clk);
    clk__enable = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    chk("cke_valid",   32'(event_valid), 32'd1);
    chk("cke_pressed", 32'(pressed),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
